// File: rtl/fractal_pkg.sv
// rtl/fractal_pkg.sv - shared state encoding, width helpers and pixel tag type for the fractal display path
// Contents:
//   state_e      IDLE / ISSUE / DRAIN
//   width_of     clog2 with a floor of one bit
//   ceil_div     integer ceiling division
//   SW/AW/XW/YW  widths for the default 640x480, single-solver configuration
//   pixel_tag_t  {x, y, sof, eol, eof} carried alongside an outstanding read
package fractal_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  localparam int DEF_NUM_SOLVERS = 1;
  localparam int DEF_NUM_COLUMNS = 640;
  localparam int DEF_NUM_ROWS    = 480;

  localparam int SW = width_of(DEF_NUM_SOLVERS);
  localparam int AW = width_of(ceil_div(DEF_NUM_COLUMNS * DEF_NUM_ROWS, DEF_NUM_SOLVERS));
  localparam int XW = width_of(DEF_NUM_COLUMNS);
  localparam int YW = width_of(DEF_NUM_ROWS);

  // Coordinates are stored at a fixed width so one tag type serves every frame size.
  localparam int TAG_CW = 16;

  typedef struct packed {
    logic [TAG_CW-1:0] x;
    logic [TAG_CW-1:0] y;
    logic              sof;
    logic              eol;
    logic              eof;
  } pixel_tag_t;

endpackage

// File: rtl/frame_streamer_if.sv
// rtl/frame_streamer_if.sv - control, solver read and pixel stream signals of frame_streamer
// Ports (master = streamer side):
//   start/busy/frame_done              frame control
//   rd_en/rd_solver_id/rd_addr/rd_data solver memory read
//   out_valid/out_ready/out_data/out_x/out_y/out_sof/out_eol/out_eof  pixel stream
interface frame_streamer_if import fractal_pkg::*; #(
  parameter int NUM_SOLVERS = 1,
  parameter int NUM_COLUMNS = 640,
  parameter int NUM_ROWS    = 480,
  parameter int ITER_WIDTH  = 16
);
  localparam int SOLV_W = width_of(NUM_SOLVERS);
  localparam int ADDR_W = width_of(ceil_div(NUM_COLUMNS * NUM_ROWS, NUM_SOLVERS));
  localparam int X_W    = width_of(NUM_COLUMNS);
  localparam int Y_W    = width_of(NUM_ROWS);

  logic                  start;
  logic                  busy;
  logic                  frame_done;
  logic                  rd_en;
  logic [SOLV_W-1:0]     rd_solver_id;
  logic [ADDR_W-1:0]     rd_addr;
  logic [ITER_WIDTH-1:0] rd_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ITER_WIDTH-1:0] out_data;
  logic [X_W-1:0]        out_x;
  logic [Y_W-1:0]        out_y;
  logic                  out_sof;
  logic                  out_eol;
  logic                  out_eof;

  modport master (
    input  start, rd_data, out_ready,
    output busy, frame_done, rd_en, rd_solver_id, rd_addr,
    output out_valid, out_data, out_x, out_y, out_sof, out_eol, out_eof
  );

  modport slave (
    output start, rd_data, out_ready,
    input  busy, frame_done, rd_en, rd_solver_id, rd_addr,
    input  out_valid, out_data, out_x, out_y, out_sof, out_eol, out_eof
  );
endinterface

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - synchronous FIFO with occupancy count
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   push, push_data   write side; a push while full is dropped unless a pop happens the same cycle
//   pop, pop_data     read side; pop_data shows the head entry whenever not empty
//   empty, count      occupancy status
module stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = (DEPTH <= 1) ? 1 : $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    do_pop  = pop && (cnt_q != '0);
    do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = ptr_next(wr_q);
    end
    if (do_pop) begin
      rd_d = ptr_next(rd_q);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign pop_data = mem_q[rd_q];
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
endmodule

// File: rtl/frame_streamer.sv
// rtl/frame_streamer.sv - raster-order reader of the solver banks with latency-aligned pixel stream output
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   bus           frame_streamer_if.master: start/busy/frame_done control, rd_* solver reads,
//                 out_* valid/ready pixel stream with sof/eol/eof markers
module frame_streamer import fractal_pkg::*; #(
  parameter int NUM_SOLVERS = 1,
  parameter int NUM_COLUMNS = 640,
  parameter int NUM_ROWS    = 480,
  parameter int ITER_WIDTH  = 16,
  parameter int RD_LATENCY  = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             clock,
  input  logic             reset,
  frame_streamer_if.master bus
);
  localparam int SOLV_W  = width_of(NUM_SOLVERS);
  localparam int ADDR_W  = width_of(ceil_div(NUM_COLUMNS * NUM_ROWS, NUM_SOLVERS));
  localparam int X_W     = width_of(NUM_COLUMNS);
  localparam int Y_W     = width_of(NUM_ROWS);
  localparam int TAG_W   = $bits(pixel_tag_t);
  localparam int ENTRY_W = TAG_W + ITER_WIDTH;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

  state_e            state_q, state_d;
  logic [SOLV_W-1:0] solver_q, solver_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  pixel_tag_t        tag_q [RD_LATENCY];
  pixel_tag_t        tag_d [RD_LATENCY];

  logic               rd_en, frame_done, last_pixel, pop, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  pixel_tag_t         cur_tag, head_tag;
  int                 in_flight;
  logic               unused_tag_bits;

  assign last_pixel = (x_q == X_W'(NUM_COLUMNS - 1)) && (y_q == Y_W'(NUM_ROWS - 1));
  assign cur_tag = '{x:   TAG_CW'(x_q),
                     y:   TAG_CW'(y_q),
                     sof: (x_q == '0) && (y_q == '0),
                     eol: (x_q == X_W'(NUM_COLUMNS - 1)),
                     eof: last_pixel};

  always_comb begin
    in_flight = 0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      in_flight = in_flight + int'(vld_q[i]);
    end
  end

  // FSM: state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = ISSUE;
      ISSUE:   if (rd_en && last_pixel) state_d = DRAIN;
      DRAIN:   if (frame_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. Reads are gated by credit so every returning word has a FIFO slot.
  always_comb begin
    bus.busy   = (state_q != IDLE);
    rd_en      = 1'b0;
    frame_done = 1'b0;
    if (state_q == ISSUE) rd_en = (in_flight + int'(fifo_count)) < FIFO_DEPTH;
    if (state_q == DRAIN) frame_done = pop && head_tag.eof;
  end

  // Raster and bank counters, plus the tag shift register that mirrors the read latency.
  always_comb begin
    solver_d = solver_q;
    addr_d   = addr_q;
    x_d      = x_q;
    y_d      = y_q;
    if (state_q == IDLE && bus.start) begin
      solver_d = '0;
      addr_d   = '0;
      x_d      = '0;
      y_d      = '0;
    end else if (rd_en) begin
      if (solver_q == SOLV_W'(NUM_SOLVERS - 1)) begin
        solver_d = '0;
        addr_d   = addr_q + 1'b1;
      end else begin
        solver_d = solver_q + 1'b1;
      end
      if (x_q == X_W'(NUM_COLUMNS - 1)) begin
        x_d = '0;
        y_d = (y_q == Y_W'(NUM_ROWS - 1)) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end

    vld_d    = vld_q;
    tag_d    = tag_q;
    vld_d[0] = rd_en;
    tag_d[0] = cur_tag;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      solver_q <= '0;
      addr_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      vld_q    <= '0;
      tag_q    <= '{default: '0};
    end else begin
      solver_q <= solver_d;
      addr_q   <= addr_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vld_q    <= vld_d;
      tag_q    <= tag_d;
    end
  end

  // The shift-register tail lines up with rd_data, so the pair is captured together.
  stream_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (vld_q[RD_LATENCY-1]),
    .push_data ({tag_q[RD_LATENCY-1], bus.rd_data}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign head_tag = fifo_head[ENTRY_W-1:ITER_WIDTH];
  assign pop      = bus.out_valid && bus.out_ready;

  // Coordinate bits above the frame size are always zero.
  assign unused_tag_bits = ^(head_tag.x >> X_W) ^ ^(head_tag.y >> Y_W);

  assign bus.rd_en        = rd_en;
  assign bus.rd_solver_id = solver_q;
  assign bus.rd_addr      = addr_q;
  assign bus.frame_done   = frame_done;
  assign bus.out_valid    = !fifo_empty;
  assign bus.out_data     = fifo_head[ITER_WIDTH-1:0];
  assign bus.out_x        = head_tag.x[X_W-1:0];
  assign bus.out_y        = head_tag.y[Y_W-1:0];
  assign bus.out_sof      = head_tag.sof;
  assign bus.out_eol      = head_tag.eol;
  assign bus.out_eof      = head_tag.eof;
endmodule
